// File: rtl/bin_to_gray.sv
// Registered Gray-to-binary converter. The legacy module name is kept, but the
// data direction is Gray in, binary out. There is one register stage, and a
// valid flag travels alongside the data.
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] bin_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] r_bin;
    logic             r_valid;

    // Prefix XOR from the MSB down: each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_bin            = '0;
        w_bin[WIDTH-1]   = gray_i[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            w_bin[WIDTH-1-k] = w_bin[WIDTH-k] ^ gray_i[WIDTH-1-k];
        end
    end

    // Output stage: load a converted word only when the input is valid, otherwise hold it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bin   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_bin <= w_bin;
            end
        end
    end

    assign bin_o   = r_bin;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray at WIDTH=4 and WIDTH=8. The reference is
// an inverse lookup table built by searching for b such that b ^ (b >> 1) == g.
module tb_bin_to_gray;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray4;
    logic       valid4;
    logic [3:0] bin4;
    logic       vout4;
    logic [7:0] gray8;
    logic       valid8;
    logic [7:0] bin8;
    logic       vout8;

    int unsigned n_checks;
    int unsigned n_errors;

    int unsigned inv4 [16];
    int unsigned inv8 [256];

    bin_to_gray #(.WIDTH(4)) u_dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .gray_i  (gray4),
        .valid_i (valid4),
        .bin_o   (bin4),
        .valid_o (vout4)
    );

    bin_to_gray #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .gray_i  (gray8),
        .valid_i (valid8),
        .bin_o   (bin8),
        .valid_o (vout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned held4;
        int unsigned held8;
        logic        v4;
        logic        v8;
        logic [3:0]  g4;
        logic [7:0]  g8;

        n_checks = 0;
        n_errors = 0;

        for (int b = 0; b < 16; b++) begin
            for (int g = 0; g < 16; g++) if ((b ^ (b >> 1)) == g) inv4[g] = b;
        end
        for (int b = 0; b < 256; b++) begin
            for (int g = 0; g < 256; g++) if ((b ^ (b >> 1)) == g) inv8[g] = b;
        end

        // Reset held with valid input present.
        rst_n  = 1'b0;
        gray4  = 4'hF;
        valid4 = 1'b1;
        gray8  = 8'hFF;
        valid8 = 1'b1;
        tick();
        tick();
        check("rst_bin4", 32'(bin4), 0);
        check("rst_vld4", 32'(vout4), 0);
        check("rst_bin8", 32'(bin8), 0);
        check("rst_vld8", 32'(vout8), 0);

        // Exhaustive Gray sweep at WIDTH=4.
        rst_n  = 1'b1;
        valid8 = 1'b0;
        for (int g = 0; g < 16; g++) begin
            gray4  = 4'(g);
            valid4 = 1'b1;
            tick();
            check($sformatf("sweep_bin_%0d", g), 32'(bin4), inv4[g]);
            check($sformatf("sweep_vld_%0d", g), 32'(vout4), 1);
        end

        // Inverse: drive the Gray code of b, expect b back.
        for (int b = 0; b < 16; b++) begin
            gray4 = 4'(b ^ (b >> 1));
            tick();
            check($sformatf("inv_%0d", b), 32'(bin4), 32'(b));
        end

        // Hold when the input goes invalid, including with unknown data.
        gray4 = 4'b0110;
        tick();
        check("hold_load", 32'(bin4), 32'h4);
        valid4 = 1'b0;
        gray4  = 4'b1001;
        tick();
        check("hold_bin", 32'(bin4), 32'h4);
        check("hold_vld", 32'(vout4), 0);
        gray4 = 4'bxxxx;
        tick();
        check("hold_x_bin", 32'(bin4), 32'h4);

        // Return to zero.
        valid4 = 1'b1;
        gray4  = 4'h0;
        tick();
        check("zero_bin", 32'(bin4), 0);
        check("zero_vld", 32'(vout4), 1);

        // WIDTH=8 boundary values.
        valid8 = 1'b1;
        gray8  = 8'b1000_0000;
        tick();
        check("w8_msb", 32'(bin8), 32'hFF);
        gray8 = 8'hFF;
        tick();
        check("w8_ones", 32'(bin8), 32'hAA);

        // Random traffic on both widths with independent valids.
        held4 = 0;
        held8 = 32'hAA;
        for (int n = 0; n < 300; n++) begin
            v4 = 1'($urandom_range(0, 1));
            v8 = 1'($urandom_range(0, 1));
            g4 = 4'($urandom);
            g8 = 8'($urandom);
            gray4  = g4;
            valid4 = v4;
            gray8  = g8;
            valid8 = v8;
            tick();
            if (v4) held4 = inv4[g4];
            if (v8) held8 = inv8[g8];
            check("rnd_bin4", 32'(bin4), held4);
            check("rnd_vld4", 32'(vout4), 32'(v4));
            check("rnd_bin8", 32'(bin8), held8);
            check("rnd_vld8", 32'(vout8), 32'(v8));
        end

        // Asynchronous reset mid-cycle, released with a valid word waiting.
        gray4  = 4'hC;
        valid4 = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bin", 32'(bin4), 0);
        check("async_vld", 32'(vout4), 0);
        gray4  = 4'h3;
        valid4 = 1'b1;
        valid8 = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("rel_valid_bin", 32'(bin4), 32'h2);
        check("rel_valid_vld", 32'(vout4), 1);

        // Release with no valid word: output stays invalid and zero.
        #2;
        rst_n = 1'b0;
        #1;
        check("async2_bin", 32'(bin4), 0);
        valid4 = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("rel_idle_bin", 32'(bin4), 0);
        check("rel_idle_vld", 32'(vout4), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bin_to_gray.md
Name: bin_to_gray

Overview:
- Registered Gray-code-to-binary converter; despite the legacy module name, data flows Gray in, binary out.
- Sits at clock-domain or counter read-back boundaries, where Gray-coded pointers or counters are turned back into binary for arithmetic.
- One pipeline register stage, with a valid flag carried alongside the data.

Parameters:
- WIDTH, default 4, bit width of the Gray input and the binary output; legal range is 2 or more.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- gray_i  input  WIDTH  Gray-coded input word.
- valid_i  input  1  gray_i is valid this cycle.
- bin_o  output  WIDTH  binary equivalent of the gray_i sampled one cycle earlier.
- valid_o  output  1  bin_o holds a converted word.

Behaviour:
- Reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
  - Asserting rst_ni low immediately forces bin_o = 0 and valid_o = 0, independent of the clock.
  - Release is sampled on the next rising edge.
- Conversion function (combinational, before the register):
  - bin[WIDTH-1] = gray[WIDTH-1]; the MSB passes straight through.
  - bin[i] = bin[i+1] XOR gray[i], for i = WIDTH-2 down to 0 (prefix XOR from the MSB).
  - Equivalently, bin[i] = XOR of gray[WIDTH-1:i].
- Latency: exactly 1 cycle. On each rising edge with rst_ni high:
  - valid_o <= valid_i.
  - If valid_i = 1, bin_o <= conv(gray_i).
  - If valid_i = 0, bin_o holds its previous value. No handshake back-pressure; the block always accepts input.
- Throughput: one word per cycle. Back-to-back valid inputs produce back-to-back valid outputs in the same order.
- No arithmetic overflow is possible; output width equals input width. Every Gray code maps to a unique binary value (bijection).
- Reset mid-stream: the word in flight is discarded; valid_o = 0 on the first edge after release unless valid_i = 1 at that edge.
- X on gray_i while valid_i = 0 must not propagate to bin_o.
- The conversion logic is purely combinational, with no latches; the only state is the bin_o and valid_o registers.

Test Plan:
- Reset: hold rst_ni = 0 with gray_i = 1111 and valid_i = 1 -> bin_o = 0000, valid_o = 0; asserting reset asynchronously mid-cycle clears both outputs at once.
- Exhaustive sweep, WIDTH = 4: drive gray_i 0000..1111 with valid_i = 1, one per cycle -> one cycle later bin_o reads, in order, 0000, 0001, 0011, 0010, 0111, 0110, 0100, 0101, 1111, 1110, 1100, 1101, 1000, 1001, 1011, 1010; valid_o = 1 throughout.
- Inverse check: for every binary b in 0..15, drive gray_i = b XOR (b>>1) -> bin_o = b one cycle later.
- Hold behaviour: gray_i = 0110 valid, then valid_i = 0 with gray_i = 1001 -> bin_o stays 0100 and valid_o drops to 0.
- Return to zero after the sweep: gray_i = 0000 -> bin_o = 0000; no glitch on valid_o across consecutive valid cycles.
- Width scaling, WIDTH = 8: gray_i = 8'b1000_0000 -> bin_o = 8'hFF; gray_i = 8'hFF -> bin_o = 8'hAA.
